// File: rtl/ppl_sort.sv
// Registered three-input sorter: compare-exchange network plus output register.
// Define PPL_SORT_ASCEND_EN to present results smallest-first instead of largest-first.
module ppl_sort #(
    parameter int width = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [width-1:0] a,
    input  logic [width-1:0] b,
    input  logic [width-1:0] c,
    output logic [width-1:0] no1,
    output logic [width-1:0] no2,
    output logic [width-1:0] no3
);

    logic [width-1:0] s1_hi;
    logic [width-1:0] s1_lo;
    logic [width-1:0] s2_hi;
    logic [width-1:0] s2_lo;
    logic [width-1:0] s3_hi;
    logic [width-1:0] s3_lo;
    logic [width-1:0] r_max;
    logic [width-1:0] r_mid;
    logic [width-1:0] r_min;

    // Bubble order: (a,b), then (hi,c), then the two losers.
    always_comb begin
        s1_hi = (a > b) ? a : b;
        s1_lo = (a > b) ? b : a;
        s2_hi = (s1_hi > c) ? s1_hi : c;
        s2_lo = (s1_hi > c) ? c : s1_hi;
        s3_hi = (s1_lo > s2_lo) ? s1_lo : s2_lo;
        s3_lo = (s1_lo > s2_lo) ? s2_lo : s1_lo;
        r_max = s2_hi;
        r_mid = s3_hi;
        r_min = s3_lo;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            no1 <= '0;
            no2 <= '0;
            no3 <= '0;
        end else begin
`ifdef PPL_SORT_ASCEND_EN
            no1 <= r_min;
            no2 <= r_mid;
            no3 <= r_max;
`else
            no1 <= r_max;
            no2 <= r_mid;
            no3 <= r_min;
`endif
        end
    end

endmodule

// File: tb/tb_ppl_sort.sv
// Scoreboard bench for ppl_sort: exhaustive, directed and random triples
// checked against a queue-sort reference model.
module tb_ppl_sort;

    localparam int W = 3;

    logic         clk;
    logic         rst;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] c;
    logic [W-1:0] no1;
    logic [W-1:0] no2;
    logic [W-1:0] no3;

    logic [3*W-1:0] exp_q[$];
    int tests;
    int fails;

    ppl_sort #(.width(W)) dut (
        .clk(clk),
        .rst(rst),
        .a  (a),
        .b  (b),
        .c  (c),
        .no1(no1),
        .no2(no2),
        .no3(no3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [3*W-1:0] ref_sort(
        input logic [W-1:0] x,
        input logic [W-1:0] y,
        input logic [W-1:0] z
    );
        int unsigned q[$];
        q = {int'(x), int'(y), int'(z)};
        q.rsort();
`ifdef PPL_SORT_ASCEND_EN
        q.reverse();
`endif
        return {W'(q[0]), W'(q[1]), W'(q[2])};
    endfunction

    task automatic check(input string name, input logic [3*W-1:0] want);
        tests++;
        if ({no1, no2, no3} !== want) begin
            fails++;
            $display("FAIL %s: got %0d,%0d,%0d want %0d,%0d,%0d", name,
                     no1, no2, no3, want[3*W-1:2*W], want[2*W-1:W], want[W-1:0]);
        end
    endtask

    // Drive on the falling edge; expectation enters the queue at the capture edge.
    task automatic send(input logic [W-1:0] x, input logic [W-1:0] y, input logic [W-1:0] z);
        @(negedge clk);
        a = x;
        b = y;
        c = z;
        @(posedge clk);
        exp_q.push_back(ref_sort(x, y, z));
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            check("sort", exp_q.pop_front());
        end
    end

    initial begin
        tests = 0;
        fails = 0;
        rst = 1'b1;
        a = 3'd7;
        b = 3'd3;
        c = 3'd1;
        #1;
        check("reset_async", '0);
        repeat (2) begin
            @(negedge clk);
            check("reset_hold", '0);
        end

        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        exp_q.push_back(ref_sort(3'd7, 3'd3, 3'd1));

        for (int i = 0; i < 512; i++) begin
            logic [8:0] v;
            v = 9'(i);
            send(v[8:6], v[5:3], v[2:0]);
        end

        send(3'd3, 3'd5, 3'd3);
        send(3'd7, 3'd7, 3'd7);
        send(3'd2, 3'd0, 3'd2);
        send(3'd0, 3'd1, 3'd2);
        send(3'd2, 3'd1, 3'd0);
        send(3'd1, 3'd2, 3'd0);
        send(3'd6, 3'd1, 3'd4);

        for (int i = 0; i < 200; i++) begin
            send(W'($urandom), W'($urandom), W'($urandom));
        end

        send(3'd4, 3'd6, 3'd5);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("reset_mid", '0);
        #1;
        rst = 1'b0;
        @(posedge clk);
        exp_q.push_back(ref_sort(3'd4, 3'd6, 3'd5));

        repeat (3) @(negedge clk);
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL drain: got %0d pending want 0", exp_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
